c64_bus_arbiter: RTL and testbench

//  Shares the system bus between the mos6510 CPU, the VIC-II and an optional

---
 rtl/c64_bus_arbiter_if.sv | 39 +++
 rtl/c64_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_c64_bus_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/c64_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// c64_bus_arbiter_if
//   Groups the bus-sharing signals between the C64 bus arbiter and the
//   agents around it: the mos6510 RDY/AEC pins, the VIC-II and expansion DMA
//   request/grant pairs, the bus-cycle strobe and the stolen-cycle counter.
//
//   Modports
//     master : the arbiter. It samples cycle_en, vic_req, dma_req and cnt_clr,
//              and drives cpu_rdy, cpu_aec, vic_grant, dma_grant, state_dbg
//              and steal_cnt.
//     slave  : the requesters, the CPU and the timing source (same signals,
//              opposite directions).
//
//   Parameter CNT_W : width of steal_cnt.
// ---------------------------------------------------------------------------
interface c64_bus_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             cycle_en;
    logic             vic_req;
    logic             dma_req;
    logic             cnt_clr;
    logic             cpu_rdy;
    logic             cpu_aec;
    logic             vic_grant;
    logic             dma_grant;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] steal_cnt;

    modport master (
        input  cycle_en, vic_req, dma_req, cnt_clr,
        output cpu_rdy, cpu_aec, vic_grant, dma_grant, state_dbg, steal_cnt
    );

    modport slave (
        output cycle_en, vic_req, dma_req, cnt_clr,
        input  cpu_rdy, cpu_aec, vic_grant, dma_grant, state_dbg, steal_cnt
    );
endinterface

// File: rtl/c64_bus_arbiter.sv
// ---------------------------------------------------------------------------
// c64_bus_arbiter
//   Shares the C64 system bus between the mos6510, the VIC-II and an optional
//   expansion-port DMA master. RDY is pulled low first; AEC (and the grant)
//   follows BA_DELAY bus cycles later, because RDY cannot stall CPU write
//   cycles and the CPU may still be in a run of up to BA_DELAY writes.
//
//   Ports
//     clk    : system clock, all state on posedge
//     reset  : synchronous, active-high; wins over cycle_en
//     bus    : c64_bus_arbiter_if.master
//                cycle_en   one-clk strobe per phi2 cycle; FSM advances only here
//                vic_req    VIC needs the bus (inverted BA)
//                dma_req    expansion DMA request (level)
//                cnt_clr    clears steal_cnt (beats the increment)
//                cpu_rdy    to 6510 RDY, 0 = halt on next read
//                cpu_aec    to 6510 AEC, 0 = CPU bus drivers off
//                vic_grant  VIC owns the bus
//                dma_grant  DMA master owns the bus
//                state_dbg  current FSM state code
//                steal_cnt  bus cycles with cpu_rdy=0, wraps
//
//   Parameters
//     BA_DELAY : bus cycles from RDY low to AEC low (>=1)
//     CNT_W    : width of steal_cnt
//
//   Build option
//     EXP_DMA_EN : when defined, the DMA requester and the DWAIT/DOWN states
//                  exist. When undefined, dma_req is ignored, dma_grant is
//                  tied 0 and a VIC release always returns to IDLE.
// ---------------------------------------------------------------------------
module c64_bus_arbiter #(
    parameter int BA_DELAY = 3,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    c64_bus_arbiter_if.master       bus
);

    localparam int DCNT_W = (BA_DELAY > 1) ? $clog2(BA_DELAY) : 1;
    localparam logic [DCNT_W-1:0] DLY_RELOAD = DCNT_W'(BA_DELAY - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VWAIT = 3'd1,
        ST_VOWN  = 3'd2,
        ST_DWAIT = 3'd3,
        ST_DOWN  = 3'd4
    } state_t;

    state_t             state_q, state_nxt;
    logic [DCNT_W-1:0]  dly_q, dly_nxt;
    logic               rdy_q, aec_q, vgnt_q, dgnt_q;
    logic               rdy_nxt, aec_nxt, vgnt_nxt, dgnt_nxt;
    logic [CNT_W-1:0]   steal_q;

    // State, delay counter, registered outputs and stolen-cycle counter.
    // The output registers load the decode of the next state, so every
    // output is a flop that moves only on a cycle_en edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            rdy_q   <= 1'b1;
            aec_q   <= 1'b1;
            vgnt_q  <= 1'b0;
            dgnt_q  <= 1'b0;
            steal_q <= '0;
        end else if (bus.cycle_en) begin
            state_q <= state_nxt;
            dly_q   <= dly_nxt;
            rdy_q   <= rdy_nxt;
            aec_q   <= aec_nxt;
            vgnt_q  <= vgnt_nxt;
            dgnt_q  <= dgnt_nxt;
            // Counts on the RDY value the CPU saw during this bus cycle.
            if (bus.cnt_clr)
                steal_q <= '0;
            else if (!rdy_q)
                steal_q <= steal_q + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        dly_nxt   = dly_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.vic_req) begin
                    state_nxt = ST_VWAIT;
                    dly_nxt   = DLY_RELOAD;
                end
`ifdef EXP_DMA_EN
                else if (bus.dma_req) begin
                    state_nxt = ST_DWAIT;
                    dly_nxt   = DLY_RELOAD;
                end
`endif
            end
            ST_VWAIT: begin
                if (!bus.vic_req)
                    state_nxt = ST_IDLE;
                else if (dly_q == '0)
                    state_nxt = ST_VOWN;
                else
                    dly_nxt = dly_q - 1'b1;
            end
            ST_VOWN: begin
                if (!bus.vic_req) begin
`ifdef EXP_DMA_EN
                    if (bus.dma_req) begin
                        state_nxt = ST_DWAIT;
                        dly_nxt   = DLY_RELOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef EXP_DMA_EN
            ST_DWAIT: begin
                // VIC preempts a pending DMA steal and restarts the BA delay.
                if (bus.vic_req) begin
                    state_nxt = ST_VWAIT;
                    dly_nxt   = DLY_RELOAD;
                end else if (!bus.dma_req) begin
                    state_nxt = ST_IDLE;
                end else if (dly_q == '0) begin
                    state_nxt = ST_DOWN;
                end else begin
                    dly_nxt = dly_q - 1'b1;
                end
            end
            ST_DOWN: begin
                // DMA gives the bus straight back; AEC returns high in VWAIT.
                if (bus.vic_req) begin
                    state_nxt = ST_VWAIT;
                    dly_nxt   = DLY_RELOAD;
                end else if (!bus.dma_req) begin
                    state_nxt = ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode of the next state
    always_comb begin
        rdy_nxt  = 1'b0;
        aec_nxt  = 1'b1;
        vgnt_nxt = 1'b0;
        dgnt_nxt = 1'b0;
        case (state_nxt)
            ST_IDLE:  rdy_nxt = 1'b1;
            ST_VOWN: begin
                aec_nxt  = 1'b0;
                vgnt_nxt = 1'b1;
            end
`ifdef EXP_DMA_EN
            ST_DOWN: begin
                aec_nxt  = 1'b0;
                dgnt_nxt = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.cpu_rdy   = rdy_q;
    assign bus.cpu_aec   = aec_q;
    assign bus.vic_grant = vgnt_q;
    assign bus.dma_grant = dgnt_q;
    assign bus.state_dbg = state_q;
    assign bus.steal_cnt = steal_q;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_c64_bus_arbiter
//   Directed-vector bench for c64_bus_arbiter with BA_DELAY=3 and a 4-bit
//   stolen-cycle counter, so counter wrap is reachable in a few cycles.
//   DMA scenarios are compiled in when EXP_DMA_EN is defined; otherwise the
//   bench checks that dma_req has no effect.
// ---------------------------------------------------------------------------
module tb_c64_bus_arbiter;

    localparam int BA_DELAY = 3;
    localparam int CNT_W    = 4;

    logic clk;
    logic reset;

    int n_vec = 0;
    int n_bad = 0;

    c64_bus_arbiter_if #(.CNT_W(CNT_W)) bus ();

    c64_bus_arbiter #(
        .BA_DELAY (BA_DELAY),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic aec,
                           input logic vg, input logic dg, input logic [2:0] st);
        chk({tag, "_rdy"}, 32'(bus.cpu_rdy),   32'(rdy));
        chk({tag, "_aec"}, 32'(bus.cpu_aec),   32'(aec));
        chk({tag, "_vg"},  32'(bus.vic_grant), 32'(vg));
        chk({tag, "_dg"},  32'(bus.dma_grant), 32'(dg));
        chk({tag, "_st"},  32'(bus.state_dbg), 32'(st));
    endtask

    // One bus cycle: a clock with cycle_en, then a clock without it.
    // Invariants are checked after every cycle_en edge.
    task automatic cyc();
        bus.cycle_en = 1'b1;
        @(posedge clk);
        #1;
        bus.cycle_en = 1'b0;
        chk("inv_two_grants", 32'(bus.vic_grant & bus.dma_grant), 32'd0);
        chk("inv_grant_aec",  32'((bus.vic_grant | bus.dma_grant) & bus.cpu_aec), 32'd0);
        chk("inv_aec_rdy",    32'(!bus.cpu_aec & bus.cpu_rdy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.cycle_en = 1'b0;
        bus.vic_req  = 1'b0;
        bus.dma_req  = 1'b0;
        bus.cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and idle
        chk_out("rst", 1, 1, 0, 0, 3'd0);
        chk("rst_steal", 32'(bus.steal_cnt), 32'd0);
        cyc();
        chk_out("idle", 1, 1, 0, 0, 3'd0);

        // VIC steal, vic_req held 10 cycle_en
        bus.vic_req = 1'b1;
        cyc();
        chk_out("v1", 0, 1, 0, 0, 3'd1);
        cyc();
        cyc();
        chk_out("v3", 0, 1, 0, 0, 3'd1);
        cyc();
        chk_out("v4", 0, 0, 1, 0, 3'd2);
        repeat (6) cyc();
        chk_out("v10", 0, 0, 1, 0, 3'd2);
        bus.vic_req = 1'b0;
        cyc();
        chk_out("vrel", 1, 1, 0, 0, 3'd0);
        chk("vrel_steal", 32'(bus.steal_cnt), 32'd10);

        // Counter wrap: 10 + 6 increments wraps a 4-bit counter to 0
        bus.vic_req = 1'b1;
        repeat (7) cyc();
        chk("wrap_steal", 32'(bus.steal_cnt), 32'd0);
        repeat (2) cyc();
        chk("pre_clr_steal", 32'(bus.steal_cnt), 32'd2);
        bus.cnt_clr = 1'b1;
        cyc();
        chk("clr_steal", 32'(bus.steal_cnt), 32'd0);
        bus.cnt_clr = 1'b0;
        cyc();
        chk("post_clr_steal", 32'(bus.steal_cnt), 32'd1);
        bus.vic_req = 1'b0;
        cyc();
        chk("rel2_steal", 32'(bus.steal_cnt), 32'd2);
        chk_out("rel2", 1, 1, 0, 0, 3'd0);

        // Abort in VWAIT: no grant ever
        bus.vic_req = 1'b1;
        cyc();
        chk_out("ab1", 0, 1, 0, 0, 3'd1);
        cyc();
        chk_out("ab2", 0, 1, 0, 0, 3'd1);
        bus.vic_req = 1'b0;
        cyc();
        chk_out("ab3", 1, 1, 0, 0, 3'd0);

        // Reset inside VOWN, together with cycle_en
        bus.vic_req = 1'b1;
        repeat (4) cyc();
        chk_out("vown", 0, 0, 1, 0, 3'd2);
        reset        = 1'b1;
        bus.cycle_en = 1'b1;
        @(posedge clk);
        #1;
        chk_out("mid_rst", 1, 1, 0, 0, 3'd0);
        chk("mid_rst_steal", 32'(bus.steal_cnt), 32'd0);
        reset        = 1'b0;
        bus.cycle_en = 1'b0;
        bus.vic_req  = 1'b0;
        @(posedge clk);
        #1;

        // cycle_en low: requests toggle, nothing moves
        bus.vic_req = 1'b1;
        repeat (2) cyc();
        chk_out("hold0", 0, 1, 0, 0, 3'd1);
        chk("hold0_steal", 32'(bus.steal_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            bus.vic_req = i[0];
            bus.dma_req = i[1];
            @(posedge clk);
            #1;
        end
        chk_out("hold1", 0, 1, 0, 0, 3'd1);
        chk("hold1_steal", 32'(bus.steal_cnt), 32'd1);
        bus.vic_req = 1'b0;
        bus.dma_req = 1'b0;
        cyc();
        chk_out("hold_rel", 1, 1, 0, 0, 3'd0);

`ifdef EXP_DMA_EN
        // Simultaneous requests: VIC first, DMA after VIC releases
        bus.vic_req = 1'b1;
        bus.dma_req = 1'b1;
        cyc();
        chk_out("sim1", 0, 1, 0, 0, 3'd1);
        repeat (3) cyc();
        chk_out("sim4", 0, 0, 1, 0, 3'd2);
        bus.vic_req = 1'b0;
        cyc();
        chk_out("dw1", 0, 1, 0, 0, 3'd3);
        repeat (2) cyc();
        chk_out("dw3", 0, 1, 0, 0, 3'd3);
        cyc();
        chk_out("down", 0, 0, 0, 1, 3'd4);

        // VIC preempts DMA ownership
        bus.vic_req = 1'b1;
        cyc();
        chk_out("pre1", 0, 1, 0, 0, 3'd1);
        repeat (2) cyc();
        chk_out("pre3", 0, 1, 0, 0, 3'd1);
        cyc();
        chk_out("pre4", 0, 0, 1, 0, 3'd2);
        bus.vic_req = 1'b0;
        cyc();
        chk_out("back_dw", 0, 1, 0, 0, 3'd3);
        bus.dma_req = 1'b0;
        cyc();
        chk_out("dma_end", 1, 1, 0, 0, 3'd0);
`else
        // DMA disabled: dma_req is ignored
        bus.dma_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_out("nodma", 1, 1, 0, 0, 3'd0);
        end
        bus.vic_req = 1'b1;
        repeat (4) cyc();
        chk_out("nodma_vown", 0, 0, 1, 0, 3'd2);
        bus.vic_req = 1'b0;
        cyc();
        chk_out("nodma_rel", 1, 1, 0, 0, 3'd0);
        bus.dma_req = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
